// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM stage.
//
// A load/store request is captured on the accept edge. The access commits
// on the edge that enters RESP, and rsp_valid is high for exactly one cycle
// in RESP. While a request waits for its response, stall stays high.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. Once accepted, the request is answered with
// exactly one rsp_valid pulse, LATENCY cycles after the accept cycle. After
// acceptance, the captured copy is used, so the requester may drop req_valid.
//
// dbg_state exposes the FSM state for checkers: 0 = IDLE, 1 = BUSY, 2 = RESP.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    // The counter only has to hold LATENCY-2, so $clog2(LATENCY) bits are enough.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT   = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
    localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            cap_we_q;
    logic [31:0]     cap_addr_q;
    logic [31:0]     cap_wdata_q;

    logic [31:0]     rdata_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            c_we;
    logic [31:0]     c_addr;
    logic [31:0]     c_wdata;
    logic [AW-1:0]   c_idx;
    logic            c_legal;
    logic            mem_wr;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Commit happens on the edge that enters RESP. With LATENCY == 1, that edge
    // is also the accept edge, so the live request fields are used. In every
    // other case, the captured copy is used.
    assign commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign c_we    = (state_q == ST_IDLE) ? req_we    : cap_we_q;
    assign c_addr  = (state_q == ST_IDLE) ? req_addr  : cap_addr_q;
    assign c_wdata = (state_q == ST_IDLE) ? req_wdata : cap_wdata_q;
    assign c_idx   = c_addr[AW+1:2];
    assign c_legal = (c_addr[1:0] == 2'b00) && (c_addr < ADDR_LIMIT);

    // The storage array has no reset, so the write is gated while reset is
    // held. This keeps a request that is present during reset out of memory.
    assign mem_wr = commit && c_we && c_legal && reset;

    // FSM state register and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> (BUSY ->)* RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the FSM state, plus the pipeline stall.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        stall     = req_valid && (state_q != ST_RESP);
        dbg_state = state_q;
    end

    // Capture the request on acceptance so it survives a withdrawn req_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
        end else if (accept) begin
            cap_we_q    <= req_we;
            cap_addr_q  <= req_addr;
            cap_wdata_q <= req_wdata;
        end
    end

    // Register the response data and error at commit; both hold until the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (!c_we && c_legal) ? mem[c_idx] : 32'h0;
            err_q   <= !c_legal;
        end
    end

    // Word storage: one write port, written only by legal committed stores.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: exercises a LATENCY=3 instance (a_*) and a LATENCY=1
// instance (b_*) of dmem_responder. Expected values are produced by a
// word-array model of memory and the latency rules.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_stall;
    logic [31:0] a_rsp_rdata;
    logic [1:0]  a_dbg;

    logic        b_valid, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_stall;
    logic [31:0] b_rsp_rdata;
    logic [1:0]  b_dbg;

    int checks;
    int errors;

    logic [31:0] model_a [64];
    logic [31:0] model_b [64];
    logic [32:0] exp_q [$];

    dmem_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (a_valid),
        .req_we    (a_we),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
        .req_ready (a_req_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err),
        .stall     (a_stall),
        .dbg_state (a_dbg)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_l1 (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (b_valid),
        .req_we    (b_we),
        .req_addr  (b_addr),
        .req_wdata (b_wdata),
        .req_ready (b_req_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err),
        .stall     (b_stall),
        .dbg_state (b_dbg)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive one requester port. sel 0 = a_* (LATENCY 3), 1 = b_* (LATENCY 1).
    task automatic drive(input int sel, input logic v, input logic we,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (sel == 0) begin
            a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
        end else begin
            b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
        end
    endtask

    // Present one request and hold it until the response arrives.
    // The task returns the latency measured from the accept cycle, or -1 on
    // timeout. It also returns the response fields and a count of cycles
    // where ready or stall behaved unlike a waiting requester would expect.
    // It is called 1 time unit after a rising edge, with the DUT idle.
    task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er, output int bad);
        int   cyc;
        logic got, rv, rr, st;
        bad = 0; lat = -1; rd = '0; er = 1'b0; got = 1'b0; cyc = 0;
        drive(sel, 1'b1, we, addr, wd);
        while (!got && cyc < 40) begin
            @(negedge clk);
            rv = (sel == 0) ? a_rsp_valid : b_rsp_valid;
            rr = (sel == 0) ? a_req_ready : b_req_ready;
            st = (sel == 0) ? a_stall     : b_stall;
            if (cyc == 0) begin
                if (rr !== 1'b1 || rv !== 1'b0) bad++;
            end else if (rr !== 1'b0) begin
                bad++;
            end
            if (st !== !rv) bad++;
            if (rv === 1'b1 && cyc > 0) begin
                got = 1'b1;
                lat = cyc;
                rd  = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
                er  = (sel == 0) ? a_rsp_err   : b_rsp_err;
            end
            @(posedge clk); #1;
            cyc++;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready, a_stall} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: valid=%b rdata=%h err=%b ready=%b stall=%b expected 0 0 0 1 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready, a_stall);
        end
        checks++;
        if ({b_rsp_valid, b_rsp_rdata, b_rsp_err, b_req_ready, b_stall} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: valid=%b rdata=%h err=%b ready=%b stall=%b expected 0 0 0 1 0",
                     b_rsp_valid, b_rsp_rdata, b_rsp_err, b_req_ready, b_stall);
        end
        checks++;
        if (a_dbg !== 2'd0 || b_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: a=%0d b=%0d expected IDLE(0)", a_dbg, b_dbg);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bad;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, bad);
        model_a[4] = 32'hDEADBEEF;
        checks++;
        if (lat != 3 || bad != 0 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL basic_store: lat=%0d bad=%0d err=%b rdata=%h expected lat=3 bad=0 err=0 rdata=0",
                     lat, bad, er, rd);
        end
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_after: ready=%b valid=%b expected 1 0", a_req_ready, a_rsp_valid);
        end
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er, bad);
        checks++;
        if (lat != 3 || bad != 0 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_load: lat=%0d bad=%0d err=%b rdata=%h expected lat=3 bad=0 err=0 rdata=deadbeef",
                     lat, bad, er, rd);
        end
    endtask

    task automatic test_lat1();
        int lat, bad, k, last, nrsp;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'h0, 32'h12345678, lat, rd, er, bad);
        model_b[0] = 32'h12345678;
        txn(1, 1'b0, 32'h0, 32'h0, lat, rd, er, bad);
        checks++;
        if (lat != 1 || bad != 0 || er !== 1'b0 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL lat1_load: lat=%0d bad=%0d err=%b rdata=%h expected lat=1 bad=0 err=0 rdata=12345678",
                     lat, bad, er, rd);
        end
        for (int i = 1; i <= 4; i++) begin
            model_b[i] = $urandom;
            txn(1, 1'b1, 32'(i * 4), model_b[i], lat, rd, er, bad);
        end
        // Back-to-back loads: valid stays high, and the address moves on after each response.
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        k = 0; last = -1; nrsp = 0;
        while (nrsp < 4 && k < 30) begin
            @(negedge clk);
            if (b_rsp_valid === 1'b1) begin
                checks++;
                if (b_rsp_rdata !== model_b[1 + nrsp]) begin
                    errors++;
                    $display("FAIL lat1_b2b_data: word %0d rdata=%h expected %h",
                             1 + nrsp, b_rsp_rdata, model_b[1 + nrsp]);
                end
                if (last >= 0) begin
                    checks++;
                    if (k - last != 2) begin
                        errors++;
                        $display("FAIL lat1_b2b_spacing: %0d cycles between responses, expected 2", k - last);
                    end
                end
                last = k;
                nrsp++;
                @(posedge clk); #1;
                if (nrsp < 4) drive(1, 1'b1, 1'b0, 32'(4 * (1 + nrsp)), 32'h0);
                else          drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                @(posedge clk); #1;
            end
            k++;
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (nrsp != 4) begin
            errors++;
            $display("FAIL lat1_b2b_count: %0d responses, expected 4", nrsp);
        end
    endtask

    task automatic test_fill();
        int lat, bad, fill_bad;
        logic [31:0] rd, wd;
        logic er;
        fill_bad = 0;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            txn(0, 1'b1, 32'(i * 4), wd, lat, rd, er, bad);
            model_a[i] = wd;
            if (lat != 3 || bad != 0 || er !== 1'b0 || rd !== 32'h0) fill_bad++;
        end
        checks++;
        if (fill_bad != 0) begin
            errors++;
            $display("FAIL fill: %0d store responses wrong, expected 0", fill_bad);
        end
    endtask

    task automatic test_illegal();
        int lat, bad;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b0, 32'h12, 32'h0, lat, rd, er, bad);
        checks++;
        if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_misaligned: lat=%0d err=%b rdata=%h expected 3 1 0", lat, er, rd);
        end
        txn(0, 1'b0, 32'h100, 32'h0, lat, rd, er, bad);
        checks++;
        if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_range: lat=%0d err=%b rdata=%h expected 3 1 0", lat, er, rd);
        end
        txn(0, 1'b1, 32'h102, 32'hCAFEF00D, lat, rd, er, bad);
        checks++;
        if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_store: lat=%0d err=%b rdata=%h expected 3 1 0", lat, er, rd);
        end
        for (int i = 0; i < 64; i++) begin
            txn(0, 1'b0, 32'(i * 4), 32'h0, lat, rd, er, bad);
            checks++;
            if (rd !== model_a[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL readback word %0d: rdata=%h err=%b expected %h 0", i, rd, er, model_a[i]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat, bad, pulses;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b1, 32'h20, 32'h11111111, lat, rd, er, bad);
        model_a[8] = 32'h11111111;
        txn(0, 1'b0, 32'h20, 32'h0, lat, rd, er, bad);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555);
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_busy_async: valid=%b rdata=%h err=%b ready=%b expected 0 0 0 1",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_busy_pulse: %0d rsp_valid pulses, expected 0", pulses);
        end
        txn(0, 1'b0, 32'h20, 32'h0, lat, rd, er, bad);
        checks++;
        if (rd !== 32'h11111111 || er !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL reset_mid_busy_mem: rdata=%h err=%b lat=%0d expected 11111111 0 3", rd, er, lat);
        end
    endtask

    task automatic test_withdrawn();
        int lat, bad, pulses, first;
        logic [31:0] rd, wd;
        logic er;
        wd = $urandom;
        drive(0, 1'b1, 1'b1, 32'h40, wd);
        pulses = 0; first = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            @(posedge clk); #1;
            if (c == 0) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        model_a[16] = wd;
        checks++;
        if (first != 3 || pulses != 1) begin
            errors++;
            $display("FAIL withdrawn_pulse: first=%0d pulses=%0d expected 3 1", first, pulses);
        end
        txn(0, 1'b0, 32'h40, 32'h0, lat, rd, er, bad);
        checks++;
        if (rd !== wd || er !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_commit: rdata=%h err=%b expected %h 0", rd, er, wd);
        end
    endtask

    task automatic test_random();
        int lat, bad, gap, r, idx;
        logic [31:0] addr, wd, rd;
        logic we, er, legal;
        logic [32:0] exp;
        for (int n = 0; n < 200; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL random_idle: valid=%b ready=%b expected 0 1", a_rsp_valid, a_req_ready);
                end
                @(posedge clk); #1;
            end
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            idx = $urandom_range(0, 63);
            r   = $urandom_range(0, 9);
            if (r == 0)      addr = 32'(idx * 4 + $urandom_range(1, 3));
            else if (r == 1) addr = ($urandom | 32'h100) & 32'hFFFF_FFFC;
            else             addr = 32'(idx * 4);
            legal = (addr % 4 == 0) && (addr < 32'd256);
            if (legal && we) model_a[addr / 4] = wd;
            exp_q.push_back({!legal, (legal && !we) ? model_a[addr / 4] : 32'h0});
            txn(0, we, addr, wd, lat, rd, er, bad);
            exp = exp_q.pop_front();
            checks++;
            if ({er, rd} !== exp || lat != 3 || bad != 0) begin
                errors++;
                $display("FAIL random op %0d addr=%h we=%b: err=%b rdata=%h lat=%0d bad=%0d expected err=%b rdata=%h lat=3 bad=0",
                         n, addr, we, er, rd, lat, bad, exp[32], exp[31:0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_basic();
        test_lat1();
        test_fill();
        test_illegal();
        test_reset_mid_busy();
        test_withdrawn();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that services the pipeline's MEM-stage load/store requests.
- Requests carry address, write enable and write data; the block answers after a configurable fixed latency.
- It drives a stall signal for the hazard unit so the pipeline can tolerate a multi-cycle data memory.
- It replaces the single-cycle data memory behind the MIPS core and sits between the MEM stage and the word-addressed storage.

Parameters:
- DEPTH, 64, number of 32-bit words of storage; power of two, >= 2.
- LATENCY, 3, cycles from request acceptance to response; integer >= 1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a load/store; held stable until rsp_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data.
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse: response/ack for the accepted request.
- rsp_rdata  out  32  load data, valid when rsp_valid.
- rsp_err  out  1  qualified by rsp_valid: misaligned or out-of-range access.
- stall  out  1  freeze request to hazard unit.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (asynchronous, reset=0): state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, captured request cleared.
- Storage array is not cleared by reset.
- req_ready = (state == IDLE).
- Accept: a request is accepted on the rising edge where req_valid && req_ready. Capture req_we, req_addr and req_wdata.
- From IDLE on accept:
  - LATENCY == 1: go to RESP.
  - Otherwise: go to BUSY with counter = LATENCY-2.
- BUSY: decrement the counter each cycle; when the counter == 0, go to RESP on the next edge.
- Access commit: the memory access is performed on the edge entering RESP.
  - Store: writes mem[idx] if legal.
  - Load: registers mem[idx] into rsp_rdata if legal, else 0.
- Timing: if the accept edge ends cycle n, rsp_valid is high during cycle n+LATENCY only (exactly one cycle). RESP -> IDLE unconditionally.
- Store responses: rsp_valid also pulses for stores (acknowledge); rsp_rdata = 0 for stores.
- Address decode:
  - idx = req_addr[log2(DEPTH)+1:2].
  - Legal iff req_addr[1:0] == 0 and req_addr < 4*DEPTH.
  - Illegal access: rsp_err = 1, no write performed, rsp_rdata = 0.
- rsp_rdata and rsp_err hold their values outside rsp_valid until the next commit.
- stall = req_valid && !rsp_valid (combinational): high from the request's first cycle through the cycle before the response; low in the response cycle so the pipeline advances.
- Requests in BUSY/RESP: req_ready = 0, so the request is not re-accepted. The request still asserted during RESP is the one being answered.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after RESP. Sustained throughput = 1 request per LATENCY+1 cycles.
- Request withdrawn: if req_valid drops while BUSY, the operation still completes and rsp_valid still pulses (the captured copy is used).
- Reset mid-operation: return to IDLE immediately.
  - An uncommitted store (not yet in RESP) is discarded; memory is unchanged.
  - A store already committed is retained.
- Store-then-load to the same address returns the new data, because commits are strictly ordered.

Test Plan:
- LATENCY=3: store addr 0x10, data 0xDEADBEEF accepted at cycle 0 -> stall = 1 in cycles 0-2; rsp_valid = 1, rsp_err = 0, stall = 0 in cycle 3; req_ready = 1 in cycle 4. Then load 0x10 -> rsp_rdata = 0xDEADBEEF exactly 3 cycles after its accept.
- LATENCY=1: load of 0x00 after storing 0x12345678 -> rsp_valid in the cycle after accept with 0x12345678; back-to-back loads are accepted every 2 cycles.
- Illegal accesses: load 0x12 (misaligned) and load 0x100 with DEPTH=64 (out of range) -> rsp_err = 1, rsp_rdata = 0. A store to 0x102 leaves all words unchanged, checked by reading back.
- Reset mid-BUSY: store 0xAAAA5555 to 0x20 (prior contents 0x11111111), assert reset one cycle after accept -> outputs go to reset values asynchronously, no rsp_valid pulse; a later load of 0x20 returns 0x11111111.
- Withdrawn request: req_valid drops during BUSY -> rsp_valid still pulses at accept+LATENCY and the store is committed.
- Randomized load/store stream vs. reference array model: all rsp_rdata values match, exactly one rsp_valid per accepted request, req_ready never high outside IDLE.
